// File: rtl/seq_serializer.sv
// Parallel-word to gapless serial bit stream feeding the overlapping sequence detector.
// First bit appears one cycle after accept; one-word hold buffer, din_ready drops while it is full.
module seq_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             in_seq,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_adv;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             in_seq_q, bit_valid_q, first_q, last_q;
    logic             head_d;
    logic             xfer;

    assign din_ready = rst && !hold_full_q;
    assign xfer      = din_valid && din_ready;
    assign busy      = (state_q == S_SHIFT) || hold_full_q;

    assign in_seq    = in_seq_q;
    assign bit_valid = bit_valid_q;
    assign first_bit = first_q;
    assign last_bit  = last_q;

    // The outgoing bit always sits at the head end of the shifter.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_adv = {shift_q[WIDTH-2:0], 1'b0};
            assign head_d    = shift_d[WIDTH-1];
        end else begin : g_lsb
            assign shift_adv = {1'b0, shift_q[WIDTH-1:1]};
            assign head_d    = shift_d[0];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    shift_d = din;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            default: begin
                if (cnt_q != CNT_LAST) begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + 1'b1;
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word goes out right after the last bit, keeping the stream gapless.
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (xfer) begin
                    shift_d = din;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            in_seq_q    <= IDLE_LEVEL;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            in_seq_q    <= (state_d == S_SHIFT) ? head_d : IDLE_LEVEL;
            bit_valid_q <= (state_d == S_SHIFT);
            first_q     <= (state_d == S_SHIFT) && (cnt_d == '0);
            last_q      <= (state_d == S_SHIFT) && (cnt_d == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Two serializer configurations driven with directed and random traffic; a slot-based stream model
// predicts every output cycle, and a monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_seq_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    typedef struct {
        int   slot;
        logic b;
        logic f;
        logic l;
    } ent_t;

    task automatic chk(input string name, input int g, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d t=%0t: got %b want %b", name, g, $time, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int         W    = (g == 0) ? 5 : 8;
        localparam bit         MSBF = (g == 0);
        localparam logic       IDL  = (g == 0) ? 1'b0 : 1'b1;
        localparam logic [7:0] P8   = (g == 0) ? 8'b0001_0110 : 8'hA5;
        localparam logic [7:0] Q8   = (g == 0) ? 8'b0000_1101 : 8'h3C;
        localparam logic [W-1:0] P  = P8[W-1:0];
        localparam logic [W-1:0] Q  = Q8[W-1:0];

        logic         rst, din_valid, din_ready, in_seq, bit_valid, first_bit, last_bit, busy;
        logic [W-1:0] din;

        // Expected stream: one entry per output slot (slot = index of the clock edge after which it shows).
        ent_t q[$];
        int   k          = 0;
        int   last_slot  = -1;
        int   last_start = -1;
        logic started    = 1'b0;
        logic acc_last   = 1'b0;

        seq_serializer #(.WIDTH(W), .MSB_FIRST(MSBF), .IDLE_LEVEL(IDL)) dut (
            .clk       (clk),
            .rst       (rst),
            .din_valid (din_valid),
            .din       (din),
            .din_ready (din_ready),
            .in_seq    (in_seq),
            .bit_valid (bit_valid),
            .first_bit (first_bit),
            .last_bit  (last_bit),
            .busy      (busy)
        );

        // A word accepted at edge k starts at k, or straight after the previous word's last bit.
        initial begin : model
            logic         s_rst, s_x;
            logic [W-1:0] s_d;
            int           st;
            forever begin
                @(negedge clk);
                #4;
                s_rst = rst;
                s_x   = rst && din_valid && din_ready;
                s_d   = din;
                @(posedge clk);
                k++;
                acc_last = s_x;
                if (!s_rst) begin
                    q.delete();
                    last_slot  = -1;
                    last_start = -1;
                    started    = 1'b1;
                end else if (s_x) begin
                    st = (k > last_slot) ? k : last_slot + 1;
                    for (int i = 0; i < W; i++)
                        q.push_back('{st + i, MSBF ? s_d[W-1-i] : s_d[i], i == 0, i == W - 1});
                    last_slot  = st + W - 1;
                    last_start = st;
                end
            end
        end

        initial begin : mon
            ent_t e;
            logic hit;
            forever begin
                @(posedge clk);
                #1;
                if (started) begin
                    hit = (q.size() > 0) && (q[0].slot == k);
                    if (hit) begin
                        e = q.pop_front();
                        chk("bit_valid", g, bit_valid, 1'b1);
                        chk("in_seq",    g, in_seq,    e.b);
                        chk("first_bit", g, first_bit, e.f);
                        chk("last_bit",  g, last_bit,  e.l);
                    end else begin
                        chk("idle_valid", g, bit_valid, 1'b0);
                        chk("idle_level", g, in_seq,    IDL);
                        chk("idle_first", g, first_bit, 1'b0);
                        chk("idle_last",  g, last_bit,  1'b0);
                    end
                    chk("din_ready", g, din_ready, rst && !(last_start > k));
                    chk("busy",      g, busy,      last_slot >= k);
                end
            end
        end

        task automatic send(input logic [W-1:0] d);
            int n;
            n         = 0;
            din_valid = 1'b1;
            din       = d;
            do begin
                @(negedge clk);
                n++;
            end while (!acc_last && n < 40);
            if (!acc_last) chk("send_timeout", g, 1'b0, 1'b1);
        endtask

        task automatic idle(input int n);
            din_valid = 1'b0;
            repeat (n) @(negedge clk);
        endtask

        task automatic do_reset(input int n);
            rst       = 1'b0;
            din_valid = 1'b0;
            repeat (n) @(negedge clk);
            rst = 1'b1;
        endtask

        initial begin : drv
            rst       = 1'b0;
            din_valid = 1'b0;
            din       = '0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            idle(2);
            send(P); idle(W + 3);
            send(P); send(P); idle(2 * W + 3);
            send(P); idle(W + 2); send(Q); idle(W + 2);
            send(P); send(P); idle(1); do_reset(1); idle(W + 3);
            send(P); idle(W + 4); send(Q); idle(W + 3);
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 99) == 0) begin
                    rst       = 1'b0;
                    din_valid = 1'b0;
                end else begin
                    rst = 1'b1;
                    if (!(din_valid && !acc_last)) begin
                        din_valid = ($urandom_range(0, 99) < 60);
                        din       = W'($urandom);
                    end
                end
                @(negedge clk);
            end
            rst = 1'b1;
            idle(2 * W + 4);
            done_cnt++;
        end
    end

    initial begin : main
        int n;
        n = 0;
        while (done_cnt < 2 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < 2) chk("run_timeout", 0, 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream feeder for the overlapping Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `in_seq`, with `bit_valid` and framing flags.
- Words sent back-to-back produce a gapless bit stream, so overlapping patterns that span word boundaries are still presented contiguously.
- One-entry holding buffer decouples the producer from the shifter.

Parameters:
- WIDTH, 8, bits per word (>=2)
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first
- IDLE_LEVEL, 0, value driven on in_seq when no bit is valid

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- din_valid  in  1  producer has a word on din
- din  in  WIDTH  parallel word
- din_ready  out  1  block can accept a word this cycle
- in_seq  out  1  serial bit to detector, registered
- bit_valid  out  1  in_seq carries a real bit this cycle, registered
- first_bit  out  1  in_seq is bit 0 of a word, registered
- last_bit  out  1  in_seq is bit WIDTH-1 of a word, registered
- busy  out  1  shifter or holding buffer occupied

Behaviour:
- Reset is sampled on the rising clk edge with rst==0. It clears the shifter, holding buffer and bit counter, and enters IDLE.
  - Outputs during and after reset: in_seq=IDLE_LEVEL, bit_valid=0, first_bit=0, last_bit=0, busy=0.
  - din_ready is forced 0 while rst==0.
- Reset mid-word: remaining bits and any held word are discarded. No partial word is resumed.
- Handshake:
  - A transfer occurs on an edge where din_valid && din_ready.
  - din_ready = rst && !hold_full (combinational from state, never from din_valid).
  - The producer must hold din stable while din_valid && !din_ready.
- States: IDLE, SHIFT. bit_cnt counts 0..WIDTH-1.
- IDLE:
  - Transfer at edge N loads the word directly into the shifter, sets bit_cnt=0 and moves to SHIFT.
  - After edge N: in_seq = first bit, bit_valid=1, first_bit=1. Latency is one cycle.
  - With no transfer: remain in IDLE with outputs at idle values.
- SHIFT, bit_cnt < WIDTH-1:
  - Each edge advances one bit and increments bit_cnt.
  - A transfer on that edge writes the holding buffer (hold_full=1).
- SHIFT, bit_cnt == WIDTH-1 (last_bit=1 this cycle). On the next edge, priority is:
  1. If hold_full: load the held word into the shifter, clear hold_full, bit_cnt=0.
  2. Else if a transfer occurs: load din directly into the shifter, bit_cnt=0.
  3. Else: go to IDLE, in_seq=IDLE_LEVEL, bit_valid=0.
  - Cases 1 and 2 produce no gap: bit_valid stays 1 and first_bit=1 on the next cycle.
- Simultaneous hold drain and new transfer cannot occur, because din_ready=0 whenever hold_full=1.
- Bit order:
  - MSB_FIRST=1: shifter shifts left and in_seq = shifter MSB.
  - MSB_FIRST=0: shifter shifts right and in_seq = shifter LSB.
- busy = (state==SHIFT) || hold_full.
- Word throughput: one word per WIDTH cycles sustained. At most one word is buffered beyond the word in flight.

Test Plan:
- WIDTH=5, MSB_FIRST=1, reset released, din=5'b10110 for one transfer:
  - in_seq = 1,0,1,1,0 on the 5 cycles after the accept edge; bit_valid=1 throughout.
  - first_bit on bit 1 only; last_bit on bit 5 only.
  - Then in_seq=0, bit_valid=0, busy=0.
- Back-to-back words 10110 then 10110, din_valid held high:
  - Second word is accepted into hold at the edge after the first; din_ready then stays 0 for 4 cycles.
  - Output is 10 contiguous valid bits 1011010110. A downstream overlapping 10110 detector fires twice.
- MSB_FIRST=0, WIDTH=8, din=8'hA5:
  - in_seq = 1,0,1,0,0,1,0,1.
  - din_ready=1 during bits 1..7 with hold empty.
- Idle gap: word 5'b10110, 3 idle cycles, then word 5'b01101:
  - Outputs are bit_valid=0 and in_seq=IDLE_LEVEL during the gap.
  - The second word starts exactly one cycle after its accept edge.
- Reset mid-word: assert rst=0 during bit 3 of 5'b10110 with a word held:
  - Next cycle all outputs are at reset values and din_ready=0.
  - After rst=1, din_ready=1, busy=0, and no stale bits are emitted.
- Producer stall: din_valid low at the last-bit edge with hold empty:
  - Transition to IDLE.
  - A later din_valid is accepted immediately because din_ready=1.
